alpha_data_emulator: RTL and testbench

ALPHA_DATA_EMULATOR -- requirements
Module: alpha_data_emulator

---
 rtl/alpha_data_emulator.sv | 182 ++++++++++++++++++
 tb/tb_alpha_data_emulator.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpha_data_emulator.sv
// ALPHA front-end data emulator: serialises a header, a fixed number of 16-bit
// data words and a one-bit-period token, MSB first, each bit held CLOCKS_PER_BIT cycles.
module alpha_data_emulator #(
    parameter logic [15:0] HEADER          = 16'hA5C3,
    parameter int          WORDS_PER_FRAME = 4,
    parameter int          CLOCKS_PER_BIT  = 1
) (
    input  logic        clock100,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        data_out,
    output logic        tok_out,
    output logic        busy,
    output logic        underrun,
    output logic [7:0]  frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_TOKEN  = 2'd3
    } state_t;

    localparam logic [7:0] PERIOD_LAST = 8'(CLOCKS_PER_BIT - 1);
    localparam logic [7:0] WORD_LAST   = 8'(WORDS_PER_FRAME - 1);

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [7:0]  period_q, period_d;
    logic [4:0]  bit_q, bit_d;
    logic [7:0]  word_q, word_d;
    logic [15:0] hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        word_ready_q, word_ready_d;
    logic        data_out_q, data_out_d;
    logic        tok_out_q, tok_out_d;
    logic        busy_q, busy_d;
    logic        underrun_q, underrun_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        bit_end_s;
    logic        slot_start_s;

    // Next-state, serialiser and holding-register logic.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        period_d      = period_q;
        bit_d         = bit_q;
        word_d        = word_q;
        data_out_d    = data_out_q;
        tok_out_d     = tok_out_q;
        busy_d        = busy_q;
        underrun_d    = underrun_q;
        frame_count_d = frame_count_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        slot_start_s  = 1'b0;
        bit_end_s     = (period_q == PERIOD_LAST);

        case (state_q)
            ST_IDLE: begin
                data_out_d = 1'b0;
                tok_out_d  = 1'b0;
                busy_d     = 1'b0;
                if (start) begin
                    state_d    = ST_HEADER;
                    shift_d    = HEADER;
                    data_out_d = HEADER[15];
                    busy_d     = 1'b1;
                    period_d   = 8'd0;
                    bit_d      = 5'd0;
                    word_d     = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HEADER, ST_DATA: begin
                if (!bit_end_s) begin
                    period_d = period_q + 8'd1;
                end else begin
                    period_d = 8'd0;
                    if (bit_q != 5'd15) begin
                        bit_d      = bit_q + 5'd1;
                        shift_d    = {shift_q[14:0], 1'b0};
                        data_out_d = shift_q[14];
                    end else if ((state_q == ST_HEADER) || (word_q != WORD_LAST)) begin
                        // Word boundary with more data to send: open the next slot.
                        bit_d        = 5'd0;
                        state_d      = ST_DATA;
                        word_d       = (state_q == ST_HEADER) ? 8'd0 : (word_q + 8'd1);
                        slot_start_s = 1'b1;
                        shift_d      = hold_full_q ? hold_q : 16'h0000;
                        data_out_d   = hold_full_q ? hold_q[15] : 1'b0;
                        underrun_d   = underrun_q | ~hold_full_q;
                    end else begin
                        bit_d      = 5'd0;
                        state_d    = ST_TOKEN;
                        data_out_d = 1'b0;
                        tok_out_d  = 1'b1;
                    end
                end
            end
            ST_TOKEN: begin
                data_out_d = 1'b0;
                if (bit_end_s) begin
                    state_d       = ST_IDLE;
                    period_d      = 8'd0;
                    tok_out_d     = 1'b0;
                    busy_d        = 1'b0;
                    frame_count_d = frame_count_q + 8'd1;
                end else begin
                    period_d = period_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                data_out_d = 1'b0;
                tok_out_d  = 1'b0;
                busy_d     = 1'b0;
            end
        endcase

        // A slot start only ever empties a full register, so it never races a transfer.
        if (slot_start_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end
        if (word_valid && !hold_full_q) begin
            hold_d      = word_in;
            hold_full_d = 1'b1;
        end else begin
            hold_d = hold_q;
        end
        word_ready_d = ~hold_full_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock100) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shift_q       <= 16'h0000;
            period_q      <= 8'd0;
            bit_q         <= 5'd0;
            word_q        <= 8'd0;
            hold_q        <= 16'h0000;
            hold_full_q   <= 1'b0;
            word_ready_q  <= 1'b1;
            data_out_q    <= 1'b0;
            tok_out_q     <= 1'b0;
            busy_q        <= 1'b0;
            underrun_q    <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            period_q      <= period_d;
            bit_q         <= bit_d;
            word_q        <= word_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            word_ready_q  <= word_ready_d;
            data_out_q    <= data_out_d;
            tok_out_q     <= tok_out_d;
            busy_q        <= busy_d;
            underrun_q    <= underrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign word_ready  = word_ready_q;
    assign data_out    = data_out_q;
    assign tok_out     = tok_out_q;
    assign busy        = busy_q;
    assign underrun    = underrun_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_alpha_data_emulator.sv
// Bench for alpha_data_emulator: two instances (defaults, and 3 clocks/bit with one word)
// checked every cycle against a frame-timeline reference model plus directed scenario checks.
module tb_alpha_data_emulator;

    localparam logic [15:0] HDR = 16'hA5C3;
    localparam int MODE_NONE = 0, MODE_FEED = 1, MODE_ALWAYS = 2, MODE_RAND = 3;

    logic        clock100;
    logic        reset;
    logic        start;
    logic [15:0] word_in;
    logic        word_valid;
    logic [1:0]  word_ready_s, data_out_s, tok_out_s, busy_s, underrun_s;
    logic [7:0]  fc_s [2];

    int          cpb_a [2] = '{1, 3};
    int          wpf_a [2] = '{4, 1};

    int          checks = 0;
    int          errors = 0;
    int          mode   = MODE_NONE;
    logic [15:0] feed_q [$];

    bit          m_active [2];
    int          m_t      [2];
    bit          m_full   [2];
    logic [15:0] m_hold   [2];
    logic [15:0] m_slot   [2][256];
    bit          m_under  [2];
    logic [7:0]  m_fc     [2];

    int          busy_cnt1, tok_cnt1;
    logic [79:0] cap;

    alpha_data_emulator u_dut0 (
        .clock100(clock100), .reset(reset), .start(start), .word_in(word_in),
        .word_valid(word_valid), .word_ready(word_ready_s[0]), .data_out(data_out_s[0]),
        .tok_out(tok_out_s[0]), .busy(busy_s[0]), .underrun(underrun_s[0]), .frame_count(fc_s[0])
    );

    alpha_data_emulator #(.HEADER(16'hA5C3), .WORDS_PER_FRAME(1), .CLOCKS_PER_BIT(3)) u_dut1 (
        .clock100(clock100), .reset(reset), .start(start), .word_in(word_in),
        .word_valid(word_valid), .word_ready(word_ready_s[1]), .data_out(data_out_s[1]),
        .tok_out(tok_out_s[1]), .busy(busy_s[1]), .underrun(underrun_s[1]), .frame_count(fc_s[1])
    );

    initial clock100 = 1'b0;
    always #5 clock100 = ~clock100;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int total_cycles(input int i);
        return (16 + 16 * wpf_a[i] + 1) * cpb_a[i];
    endfunction

    // Expected serial bit from the position in the frame timeline.
    function automatic logic exp_data(input int i);
        logic [15:0] h;
        logic [15:0] w;
        int b;
        h = HDR;
        if (!m_active[i]) return 1'b0;
        b = m_t[i] / cpb_a[i];
        if (b < 16) return h[15 - b];
        if (b < 16 + 16 * wpf_a[i]) begin
            w = m_slot[i][(b - 16) / 16];
            return w[15 - ((b - 16) % 16)];
        end
        return 1'b0;
    endfunction

    function automatic logic exp_tok(input int i);
        return m_active[i] && (m_t[i] >= (16 + 16 * wpf_a[i]) * cpb_a[i]);
    endfunction

    // One clock: drive word inputs, advance the model on the edge, then compare all outputs.
    task automatic tick();
        bit rdy_pre;
        bit pop_now;
        int rel;
        case (mode)
            MODE_FEED: begin
                word_valid = (feed_q.size() > 0) && !m_full[0];
                word_in    = (feed_q.size() > 0) ? feed_q[0] : 16'h0000;
            end
            MODE_ALWAYS: begin
                word_valid = 1'b1;
                word_in    = 16'($urandom);
            end
            MODE_RAND: begin
                word_valid = 1'($urandom_range(0, 1));
                word_in    = 16'($urandom);
            end
            default: begin
                word_valid = 1'b0;
                word_in    = 16'($urandom);
            end
        endcase
        pop_now = (mode == MODE_FEED) && word_valid && !m_full[0] && !reset;
        @(posedge clock100);
        for (int i = 0; i < 2; i++) begin
            rdy_pre = !m_full[i];
            if (reset) begin
                m_active[i] = 1'b0;
                m_t[i]      = 0;
                m_full[i]   = 1'b0;
                m_under[i]  = 1'b0;
                m_fc[i]     = 8'd0;
            end else begin
                if (m_active[i]) begin
                    if (m_t[i] == total_cycles(i) - 1) begin
                        m_active[i] = 1'b0;
                        m_fc[i]     = m_fc[i] + 8'd1;
                    end else begin
                        m_t[i] = m_t[i] + 1;
                        rel    = m_t[i] - 16 * cpb_a[i];
                        if (rel >= 0 && rel < 16 * wpf_a[i] * cpb_a[i] && (rel % (16 * cpb_a[i])) == 0) begin
                            if (m_full[i]) begin
                                m_slot[i][rel / (16 * cpb_a[i])] = m_hold[i];
                                m_full[i] = 1'b0;
                            end else begin
                                m_slot[i][rel / (16 * cpb_a[i])] = 16'h0000;
                                m_under[i] = 1'b1;
                            end
                        end
                    end
                end else if (start) begin
                    m_active[i] = 1'b1;
                    m_t[i]      = 0;
                end
                if (word_valid && rdy_pre) begin
                    m_hold[i] = word_in;
                    m_full[i] = 1'b1;
                end
            end
        end
        if (pop_now) void'(feed_q.pop_front());
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("data_out%0d", i), data_out_s[i], exp_data(i));
            chk($sformatf("tok_out%0d", i), tok_out_s[i], exp_tok(i));
            chk($sformatf("busy%0d", i), busy_s[i], m_active[i]);
            chk($sformatf("word_ready%0d", i), word_ready_s[i], !m_full[i]);
            chk($sformatf("underrun%0d", i), underrun_s[i], m_under[i]);
            chk($sformatf("frame_count%0d", i), fc_s[i], m_fc[i]);
        end
        busy_cnt1 += int'(busy_s[1]);
        tok_cnt1  += int'(tok_out_s[1]);
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        chk("rst_word_ready", word_ready_s, 2'b11);
        chk("rst_busy", busy_s, 2'b00);
        chk("rst_data_tok", {data_out_s, tok_out_s, underrun_s}, 6'b0);
        chk("rst_fc", {fc_s[0], fc_s[1]}, 16'h0000);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_active[0] || m_active[1]) && n < 2000) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy_s, 2'b00);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        word_in    = 16'h0000;
        word_valid = 1'b0;
        cap        = 80'h0;
        #1;
        do_reset();
        repeat (2) tick();

        // Preloaded word plus three words fed as the holding register empties.
        feed_q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        mode   = MODE_FEED;
        tick();
        start = 1'b1;
        tick();
        chk("first_header_bit", {busy_s[0], data_out_s[0]}, 2'b11);
        cap = {cap[78:0], data_out_s[0]};
        for (int k = 0; k < 79; k++) begin
            tick();
            cap = {cap[78:0], data_out_s[0]};
        end
        chk("stream80", cap, 80'hA5C3_1234_5678_9ABC_DEF0);
        tick();
        chk("token0", tok_out_s[0], 1'b1);
        tick();
        chk("token0_end", {tok_out_s[0], busy_s[0]}, 2'b00);
        chk("fc_after_frame", fc_s[0], 8'd1);
        chk("no_underrun", underrun_s[0], 1'b0);
        wait_idle();

        // Slow instance: 3 clocks per bit, one word.
        do_reset();
        feed_q = '{16'h8001};
        tick();
        busy_cnt1 = 0;
        tok_cnt1  = 0;
        start = 1'b1;
        tick();
        wait_idle();
        repeat (3) tick();
        chk("busy1_cycles", busy_cnt1, 80'd99);
        chk("tok1_cycles", tok_cnt1, 80'd3);
        chk("fc1_after_frame", fc_s[1], 8'd1);

        // No words at all: zero slots and sticky underrun.
        do_reset();
        mode  = MODE_NONE;
        start = 1'b1;
        tick();
        while (m_t[0] < 15) tick();
        chk("underrun_before_slot", underrun_s[0], 1'b0);
        while (m_t[0] < 17) tick();
        chk("underrun_after_slot", underrun_s[0], 1'b1);
        wait_idle();
        chk("fc_underrun_frame", fc_s[0], 8'd1);
        repeat (3) tick();
        chk("underrun_sticky", underrun_s[0], 1'b1);

        // Extra starts mid-frame and on the token cycle are ignored.
        mode  = MODE_RAND;
        start = 1'b1;
        tick();
        while (m_t[0] < 40) tick();
        start = 1'b1;
        tick();
        while (m_active[0] && m_t[0] < total_cycles(0) - 1) tick();
        start = 1'b1;
        tick();
        chk("token_start_ignored", busy_s[0], 1'b0);
        wait_idle();
        repeat (4) tick();
        chk("fc_single_frame", fc_s[0], 8'd2);

        // Reset at bit 30 aborts the frame; a fresh frame then completes.
        start = 1'b1;
        tick();
        while (m_t[0] < 30) tick();
        do_reset();
        mode  = MODE_ALWAYS;
        tick();
        start = 1'b1;
        tick();
        wait_idle();
        chk("fc_after_abort", fc_s[0], 8'd1);

        // 256 back-to-back frames with data always available: counter wraps.
        do_reset();
        for (int f = 0; f < 256; f++) begin
            start = 1'b1;
            tick();
            wait_idle();
            if (f == 254) chk("fc_255", fc_s[0], 8'd255);
        end
        chk("fc_wrap0", fc_s[0], 8'd0);
        chk("fc_wrap1", fc_s[1], 8'd0);
        chk("no_underrun_256", underrun_s[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
